// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
// Byte-enable encodings and owner/state enums used by the top and the grant picker.
`timescale 1ns/1ps
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    P0 = 1'b0,
    P1 = 1'b1
  } owner_t;

  localparam logic [3:0] BE_READ = 4'b0000;
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/sram_arbiter_arb2_pick.sv
// Two-input grant picker. With ARB_ROUND_ROBIN_EN the prio input selects the favoured
// port; without it port 1 always wins and the prio input does not exist.
`timescale 1ns/1ps
module arb2_pick
  import sram_arbiter_pkg::*;
(
  input  logic [1:0] req,
`ifdef ARB_ROUND_ROBIN_EN
  input  owner_t     prio,
`endif
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
    if (prio == P0) begin
      gnt = req[0] ? 2'b01 : (req[1] ? 2'b10 : 2'b00);
    end else begin
      gnt = req[1] ? 2'b10 : (req[0] ? 2'b01 : 2'b00);
    end
`else
    gnt = req[1] ? 2'b10 : (req[0] ? 2'b01 : 2'b00);
`endif
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port SRAM between instruction fetch (port 0) and load/store (port 1).
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority to port 1.
`timescale 1ns/1ps
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                p0_req,
  input  logic [DATA_W/8-1:0] p0_we,
  input  logic [ADDR_W-1:0]   p0_addr,
  input  logic [DATA_W-1:0]   p0_wdata,
  output logic                p0_gnt,
  output logic                p0_done,
  output logic [DATA_W-1:0]   p0_rdata,
  input  logic                p1_req,
  input  logic [DATA_W/8-1:0] p1_we,
  input  logic [ADDR_W-1:0]   p1_addr,
  input  logic [DATA_W-1:0]   p1_wdata,
  output logic                p1_gnt,
  output logic                p1_done,
  output logic [DATA_W-1:0]   p1_rdata,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic                sram_read,
  output logic [DATA_W/8-1:0] sram_write,
  output logic [DATA_W-1:0]   sram_di,
  input  logic [DATA_W-1:0]   sram_do
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  generate
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("sram_arbiter: WAIT_CYCLES must be in 1..15");
    end
  endgenerate

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic [BE_W-1:0]     we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0]   p1_rdata_q, p1_rdata_d;
  logic [1:0]          pick;
  logic [1:0]          gnt_v;
`ifdef ARB_ROUND_ROBIN_EN
  owner_t              ptr_q, ptr_d;
`endif

  arb2_pick u_pick (
    .req  ({p1_req, p0_req}),
`ifdef ARB_ROUND_ROBIN_EN
    .prio (ptr_q),
`endif
    .gnt  (pick)
  );

  // Grant is suppressed while reset is held: an acknowledged request would otherwise be lost.
  assign gnt_v = (state_q == IDLE && rst) ? pick : 2'b00;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    ptr_d      = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt_v != 2'b00) begin
          owner_d = gnt_v[1] ? P1 : P0;
          we_d    = gnt_v[1] ? p1_we    : p0_we;
          addr_d  = gnt_v[1] ? p1_addr  : p0_addr;
          wdata_d = gnt_v[1] ? p1_wdata : p0_wdata;
          cnt_d   = '0;
          state_d = ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
          ptr_d   = gnt_v[1] ? P0 : P1;
`endif
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          if (we_q == '0) begin
            if (owner_q == P0) p0_rdata_d = sram_do;
            else               p1_rdata_d = sram_do;
          end
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= P0;
      we_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q      <= P0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign p0_gnt     = gnt_v[0];
  assign p1_gnt     = gnt_v[1];
  assign p0_done    = (state_q == RESP) && (owner_q == P0);
  assign p1_done    = (state_q == RESP) && (owner_q == P1);
  assign p0_rdata   = p0_rdata_q;
  assign p1_rdata   = p1_rdata_q;
  assign sram_addr  = addr_q;
  assign sram_di    = wdata_q;
  assign sram_read  = (state_q == ACCESS) && (we_q == '0);
  assign sram_write = (state_q == ACCESS) ? we_q : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: one instance with WAIT_CYCLES=1, one with WAIT_CYCLES=3,
// each attached to a behavioural SRAM (combinational read, negedge byte write, backdoor preload).
`timescale 1ns/1ps
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int AW = 14;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          p0_req, p1_req, p0_gnt, p1_gnt, p0_done, p1_done;
  logic [3:0]    p0_we, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata;
  logic [AW-1:0] sram_addr;
  logic          sram_read;
  logic [3:0]    sram_write;
  logic [DW-1:0] sram_di, sram_do;

  logic          w0_req, w1_req, w0_gnt, w1_gnt, w0_done, w1_done;
  logic [3:0]    w0_we, w1_we;
  logic [AW-1:0] w0_addr, w1_addr;
  logic [DW-1:0] w0_wdata, w1_wdata, w0_rdata, w1_rdata;
  logic [AW-1:0] w_sram_addr;
  logic          w_sram_read;
  logic [3:0]    w_sram_write;
  logic [DW-1:0] w_sram_di, w_sram_do;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
    .sram_addr(sram_addr), .sram_read(sram_read), .sram_write(sram_write),
    .sram_di(sram_di), .sram_do(sram_do)
  );

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst),
    .p0_req(w0_req), .p0_we(w0_we), .p0_addr(w0_addr), .p0_wdata(w0_wdata),
    .p0_gnt(w0_gnt), .p0_done(w0_done), .p0_rdata(w0_rdata),
    .p1_req(w1_req), .p1_we(w1_we), .p1_addr(w1_addr), .p1_wdata(w1_wdata),
    .p1_gnt(w1_gnt), .p1_done(w1_done), .p1_rdata(w1_rdata),
    .sram_addr(w_sram_addr), .sram_read(w_sram_read), .sram_write(w_sram_write),
    .sram_di(w_sram_di), .sram_do(w_sram_do)
  );

  // Behavioural SRAMs; the backdoor port (bd_*) lets the bench preload or alter words.
  logic [DW-1:0] mem  [0:(1<<AW)-1];
  logic [DW-1:0] mem3 [0:(1<<AW)-1];
  logic          bd_we = 1'b0;
  logic          bd_sel = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  assign sram_do   = mem[sram_addr];
  assign w_sram_do = mem3[w_sram_addr];

  always @(negedge clk) begin
    if (bd_we && !bd_sel) mem[bd_addr] = bd_data;
    if (bd_we && bd_sel)  mem3[bd_addr] = bd_data;
    for (int b = 0; b < 4; b++) begin
      if (sram_write[b])   mem[sram_addr][8*b +: 8]    = sram_di[8*b +: 8];
      if (w_sram_write[b]) mem3[w_sram_addr][8*b +: 8] = w_sram_di[8*b +: 8];
    end
  end

  typedef struct packed {
    logic          port;
    logic          is_read;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic preload(input logic sel, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bd_sel  = sel;
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    step();
    bd_we   = 1'b0;
  endtask

  task automatic test_reset();
    logic saw;
    p0_req = 1'b1; p0_we = BE_WORD; p0_addr = 14'h005; p0_wdata = 32'hCAFEF00D;
    preload(1'b0, 14'h005, 32'h0);
    n_checks++;
    if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin
      n_fail++; $display("FAIL reset_gnt: got %b%b expected 00", p1_gnt, p0_gnt);
    end
    n_checks++;
    if ({p0_done, p1_done, sram_read, sram_write} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0", {p0_done, p1_done, sram_read, sram_write});
    end
    n_checks++;
    if ({p0_rdata, p1_rdata, sram_addr, sram_di} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h/%h/%h/%h expected zeros", p0_rdata, p1_rdata, sram_addr, sram_di);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (p0_gnt !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_gnt: got %b expected 1", p0_gnt);
    end
    step();
    p0_req = 1'b0;
    n_checks++;
    if (sram_write !== 4'hF) begin
      n_fail++; $display("FAIL pre_abort_write: got %h expected f", sram_write);
    end
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (sram_write !== 4'h0 || sram_read !== 1'b0) begin
      n_fail++; $display("FAIL abort_ctrl: got write=%h read=%b expected 0/0", sram_write, sram_read);
    end
    n_checks++;
    if ({p0_gnt, p0_done, sram_addr, sram_di} !== '0) begin
      n_fail++; $display("FAIL abort_outputs: got gnt=%b done=%b addr=%h di=%h expected zeros", p0_gnt, p0_done, sram_addr, sram_di);
    end
    step();
    step();
    rst = 1'b1;
    saw = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (p0_done || p1_done) saw = 1'b1;
    end
    n_checks++;
    if (saw !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_done: got done seen=%b expected 0", saw);
    end
    $display("txn reset-abort p0 write 0x005 checked");
  endtask

  task automatic test_single_read();
    sb.delete();
    preload(1'b0, 14'h010, 32'hDEADBEEF);
    p0_req = 1'b1; p0_we = BE_READ; p0_addr = 14'h010;
    #1;
    n_checks++;
    if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin
      n_fail++; $display("FAIL read_gnt_cyc0: got p0_gnt=%b p1_gnt=%b expected 1/0", p0_gnt, p1_gnt);
    end else begin
      sb.push_back(exp_t'{1'b0, 1'b1, 32'hDEADBEEF});
    end
    step();
    p0_req = 1'b0;
    n_checks++;
    if (sram_read !== 1'b1 || sram_addr !== 14'h010 || p0_done !== 1'b0) begin
      n_fail++; $display("FAIL read_access_cyc1: got read=%b addr=%h done=%b expected 1/010/0", sram_read, sram_addr, p0_done);
    end
    step();
    n_checks++;
    if (p0_done !== 1'b1 || sram_read !== 1'b0) begin
      n_fail++; $display("FAIL read_done_cyc2: got done=%b read=%b expected 1/0", p0_done, sram_read);
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if (p0_rdata !== e.data) begin
        n_fail++; $display("FAIL read_data: got %h expected %h", p0_rdata, e.data);
      end
      $display("txn port=0 read addr=010 rdata=%h", p0_rdata);
    end
    step();
    n_checks++;
    if (p0_done !== 1'b0) begin
      n_fail++; $display("FAIL read_done_pulse: got %b expected 0", p0_done);
    end
  endtask

  task automatic test_byte_write();
    logic got_gnt, got_done;
    sb.delete();
    preload(1'b0, 14'h3FFF, 32'h11223344);
    for (int ph = 0; ph < 2; ph++) begin
      p1_req = 1'b1; p1_addr = 14'h3FFF; p1_wdata = 32'h0000AB00;
      p1_we  = (ph == 0) ? 4'b0010 : BE_READ;
      got_gnt = 1'b0; got_done = 1'b0;
      for (int c = 0; c < 8 && !got_done; c++) begin
        #1;
        if (p1_gnt && !got_gnt) begin
          got_gnt = 1'b1;
          sb.push_back(exp_t'{1'b1, 1'(ph == 1), 32'h1122AB44});
        end
        if (p1_done && sb.size() > 0) begin
          got_done = 1'b1;
          e = sb.pop_front();
          if (e.is_read) begin
            n_checks++;
            if (p1_rdata !== e.data) begin
              n_fail++; $display("FAIL byte_write_readback: got %h expected %h", p1_rdata, e.data);
            end
          end
          n_checks++;
          if (p0_rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL nonowner_rdata: got %h expected deadbeef", p0_rdata);
          end
          $display("txn port=1 %s addr=3fff rdata=%h", e.is_read ? "read" : "write", p1_rdata);
        end
        step();
        if (got_gnt) p1_req = 1'b0;
      end
      n_checks++;
      if (got_done !== 1'b1) begin
        n_fail++; $display("FAIL byte_write_timeout: got done=%b expected 1 (phase %0d)", got_done, ph);
      end
      p1_req = 1'b0;
    end
  endtask

  task automatic test_contention();
    int   grants, dones, last;
    logic drop0, drop1, port, exp_port;
    sb.delete();
    preload(1'b0, 14'h020, 32'hA0A0A0A0);
    preload(1'b0, 14'h021, 32'hB1B1B1B1);
    p0_we = BE_READ; p0_addr = 14'h020;
    p1_we = BE_READ; p1_addr = 14'h021;
    p0_req = 1'b1; p1_req = 1'b1;
    grants = 0; dones = 0; last = 0; drop0 = 1'b0; drop1 = 1'b0;
    for (int c = 0; c < 60 && dones < 4; c++) begin
      if (drop0) p0_req = 1'b0;
      if (drop1) p1_req = 1'b0;
      #1;
      if (p0_gnt || p1_gnt) begin
        port = p1_gnt;
`ifdef ARB_ROUND_ROBIN_EN
        exp_port = grants[0];
`else
        exp_port = (grants < 3);
`endif
        n_checks++;
        if ((p0_gnt && p1_gnt) || port !== exp_port) begin
          n_fail++; $display("FAIL grant_order: grant %0d got p0=%b p1=%b expected port %0d", grants, p0_gnt, p1_gnt, exp_port);
        end
        if (grants > 0) begin
          n_checks++;
          if (c - last != 3) begin
            n_fail++; $display("FAIL grant_spacing: got %0d cycles expected 3", c - last);
          end
        end
        last = c;
        sb.push_back(exp_t'{port, 1'b1, port ? 32'hB1B1B1B1 : 32'hA0A0A0A0});
        grants++;
`ifdef ARB_ROUND_ROBIN_EN
        if (grants == 4) begin drop0 = 1'b1; drop1 = 1'b1; end
`else
        if (grants == 3) drop1 = 1'b1;
        if (grants == 4) drop0 = 1'b1;
`endif
      end
      if ((p0_done || p1_done) && sb.size() > 0) begin
        e = sb.pop_front();
        dones++;
        n_checks++;
        if (p1_done !== e.port || (e.port ? p1_rdata : p0_rdata) !== e.data) begin
          n_fail++; $display("FAIL contention_done: got p0_done=%b p1_done=%b data=%h expected port %0d data %h",
                             p0_done, p1_done, e.port ? p1_rdata : p0_rdata, e.port, e.data);
        end
        $display("txn contention port=%0d rdata=%h", e.port, e.port ? p1_rdata : p0_rdata);
      end
      step();
    end
    n_checks++;
    if (dones != 4) begin
      n_fail++; $display("FAIL contention_timeout: got %0d dones expected 4", dones);
    end
    p0_req = 1'b0; p1_req = 1'b0;
  endtask

  task automatic test_wait3();
    int   reads;
    logic got_done;
    sb.delete();
    preload(1'b1, 14'h123, 32'h11111111);
    w0_req = 1'b1; w0_we = BE_READ; w0_addr = 14'h123;
    #1;
    n_checks++;
    if (w0_gnt !== 1'b1) begin
      n_fail++; $display("FAIL wait3_gnt: got %b expected 1", w0_gnt);
    end else begin
      sb.push_back(exp_t'{1'b0, 1'b1, 32'h33333333});
    end
    reads = 0; got_done = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) begin
        w0_req = 1'b0;
        bd_sel = 1'b1; bd_addr = 14'h123; bd_data = 32'h22222222; bd_we = 1'b1;
      end
      if (c == 2) bd_data = 32'h33333333;
      if (c == 3) bd_we = 1'b0;
      if (w_sram_read === 1'b1) reads++;
      if (w0_done === 1'b1) begin
        got_done = 1'b1;
        n_checks++;
        if (c != 4) begin
          n_fail++; $display("FAIL wait3_done_cycle: got cycle %0d expected 4", c);
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          n_checks++;
          if (w0_rdata !== e.data) begin
            n_fail++; $display("FAIL wait3_data: got %h expected %h", w0_rdata, e.data);
          end
        end
        $display("txn wait3 port=0 read addr=123 rdata=%h", w0_rdata);
      end
    end
    n_checks++;
    if (reads != 3) begin
      n_fail++; $display("FAIL wait3_read_cycles: got %0d expected 3", reads);
    end
    n_checks++;
    if (got_done !== 1'b1) begin
      n_fail++; $display("FAIL wait3_timeout: got done=%b expected 1", got_done);
    end
  endtask

  initial begin
    p0_req = 1'b0; p0_we = '0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = '0; p1_addr = '0; p1_wdata = '0;
    w0_req = 1'b0; w0_we = '0; w0_addr = '0; w0_wdata = '0;
    w1_req = 1'b0; w1_we = '0; w1_addr = '0; w1_wdata = '0;
    test_reset();
    test_single_read();
    test_byte_write();
    test_contention();
    test_wait3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
